// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg -- parametrised pipeline stage register with a 2-entry skid
// buffer, valid/ready handshake and synchronous flush.
//
// The control bundle is zeroed whenever an entry leaves or is flushed, so a
// bubble always reads as a NOP on out_ctrl. The data bundle is never cleared
// except by reset; consumers qualify it with out_valid.
//
// Optional feature: define PIPE_STAGE_STATS_EN to add the COUNT_W parameter
// and the saturating stall_count output. Without the macro the port, the
// parameter and the counter are absent and everything else is identical.
module pipe_stage_reg #(
    parameter int CTRL_W  = 15,
    parameter int DATA_W  = 96
`ifdef PIPE_STAGE_STATS_EN
    ,
    parameter int COUNT_W = 16
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [COUNT_W-1:0] stall_count
`endif
);

    // Occupancy is encoded as {skid_valid, main_valid}; 2'b10 is unreachable.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } state_t;

    state_t            state_reg;

    logic [CTRL_W-1:0] main_ctrl_reg;
    logic [DATA_W-1:0] main_data_reg;
    logic [CTRL_W-1:0] skid_ctrl_reg;
    logic [DATA_W-1:0] skid_data_reg;

    logic              main_valid;
    logic              skid_valid;
    logic              in_fire;
    logic              out_fire;

    assign main_valid = state_reg[0];
    assign skid_valid = state_reg[1];

    // in_ready comes straight from the skid occupancy bit, so there is no
    // combinational path from out_ready back to the upstream stage.
    assign in_ready  = ~skid_valid;
    assign out_valid = main_valid;
    assign out_ctrl  = main_ctrl_reg;
    assign out_data  = main_data_reg;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = main_valid & out_ready;

    // Occupancy state machine and main/skid entry storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= EMPTY;
            main_ctrl_reg <= '0;
            main_data_reg <= '0;
            skid_ctrl_reg <= '0;
            skid_data_reg <= '0;
        end else if (flush) begin
            // Flush beats any handshake: both entries become bubbles and a
            // simultaneous incoming entry is dropped. Data is left as-is.
            state_reg     <= EMPTY;
            main_ctrl_reg <= '0;
            skid_ctrl_reg <= '0;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (in_fire) begin
                        state_reg     <= ONE;
                        main_ctrl_reg <= in_ctrl;
                        main_data_reg <= in_data;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        // Pass-through at full rate: replace the leaving entry.
                        main_ctrl_reg <= in_ctrl;
                        main_data_reg <= in_data;
                    end else if (in_fire) begin
                        // Downstream stalled: park the new entry in the skid slot.
                        state_reg     <= FULL;
                        skid_ctrl_reg <= in_ctrl;
                        skid_data_reg <= in_data;
                    end else if (out_fire) begin
                        // Entry left with nothing behind it; present a NOP.
                        state_reg     <= EMPTY;
                        main_ctrl_reg <= '0;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        // Promote the older skid entry to keep acceptance order.
                        state_reg     <= ONE;
                        main_ctrl_reg <= skid_ctrl_reg;
                        main_data_reg <= skid_data_reg;
                        skid_ctrl_reg <= '0;
                    end
                end
                default: begin
                    // Unreachable encoding: recover to a clean empty stage.
                    state_reg     <= EMPTY;
                    main_ctrl_reg <= '0;
                    skid_ctrl_reg <= '0;
                end
            endcase
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    logic [COUNT_W-1:0] stall_count_reg;

    assign stall_count = stall_count_reg;

    // Count cycles where an entry is presented but not taken; saturate at
    // all-ones. Flush leaves it alone so stall history survives pipeline
    // redirects.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count_reg <= '0;
        end else if (main_valid && !out_ready && (stall_count_reg != '1)) begin
            stall_count_reg <= stall_count_reg + 1'b1;
        end
    end
`endif

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline stage register: the general replacement for the fixed ID/EX latch between any two stages of the processor pipeline.
- Carries a control bundle and a data bundle with a valid/ready handshake.
- A 2-entry skid buffer lets the stage absorb downstream stalls at full throughput.
- Synchronous flush inserts bubbles: control is zeroed, giving a NOP.

Parameters:
CTRL_W, 15, control bundle width (default packs mux4, data_mem, alu[5:0], regs_bank[1:0], regC_adress[3:0], write_inst)
DATA_W, 96, data bundle width (default packs {pc, regB, regA}, 32 bits each)
COUNT_W, 16, stall counter width (used only with the optional feature)

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  asynchronous, active-high reset
flush  input  1  synchronous flush; discards all held entries
in_valid  input  1  upstream has an entry
in_ready  output  1  stage can accept an entry; equals NOT skid_valid
in_ctrl  input  CTRL_W  upstream control bundle
in_data  input  DATA_W  upstream data bundle
out_valid  output  1  stage presents an entry
out_ready  input  1  downstream accepts the entry
out_ctrl  output  CTRL_W  control bundle; 0 whenever out_valid=0
out_data  output  DATA_W  data bundle
stall_count  output  COUNT_W  only when PIPE_STAGE_STATS_EN is defined

Behaviour:
- Handshake terms:
  - in_fire = in_valid & in_ready
  - out_fire = out_valid & out_ready
- Storage:
  - main entry (main_valid, main_ctrl, main_data) drives the outputs
  - skid entry (skid_valid, skid_ctrl, skid_data)
- Outputs:
  - out_valid = main_valid; out_ctrl = main_ctrl; out_data = main_data
  - in_ready = ~skid_valid, driven directly from the register with no combinational path from out_ready
- Reset (asynchronous, immediate):
  - main_valid = skid_valid = 0
  - all ctrl registers = 0
  - all data registers = 0
  - in_ready = 1, out_valid = 0, out_ctrl = 0, out_data = 0
- States (encoded by {skid_valid, main_valid}):
  - EMPTY (00):
    - in_fire -> ONE, main <= in
    - otherwise hold
  - ONE (01):
    - in_fire & out_fire -> ONE, main <= in
    - in_fire & !out_fire -> FULL, skid <= in
    - !in_fire & out_fire -> EMPTY, main_ctrl <= 0
    - otherwise hold
  - FULL (11):
    - in_ready = 0
    - out_fire -> ONE, main <= skid, skid_valid <= 0, skid_ctrl <= 0
    - otherwise hold
  - State 10 is illegal and never reached.
- Flush has priority over every handshake in the same cycle:
  - next state EMPTY
  - main_ctrl = skid_ctrl = 0
  - any simultaneous in_fire entry is discarded
  - data registers hold their values
- Latency: 1 cycle from in_fire to out_valid when EMPTY.
- Throughput: 1 entry per cycle while out_ready = 1.
- Order: entries exit in acceptance order; none dropped or duplicated except by flush.
- Stability: while out_valid=1 and out_ready=0, out_ctrl and out_data do not change.
- out_data after an entry exits holds its last value; consumers qualify it with out_valid.
- in_valid while in_ready=0: no effect, no state change.
- Reset asserted mid-transfer: outputs go to reset values immediately; no entry survives.

Optional Feature:
- Macro: PIPE_STAGE_STATS_EN
- Defined:
  - adds port stall_count[COUNT_W-1:0], reset to 0
  - increments each cycle with out_valid=1 and out_ready=0
  - saturates at all-ones
  - flush does not clear it; only reset clears it
- Undefined:
  - port and counter are absent
  - all other behaviour is identical

Test Plan:
1. Reset then single entry: reset=1 for 12 ns, release; in_ctrl=15'h4E53, in_data={620,240,100}, in_valid=1 for one cycle, out_ready=1 -> out_valid=1 with exact values on the next edge; out_valid=0 and out_ctrl=0 the edge after.
2. Back-to-back throughput: 8 consecutive entries with data 1..8, out_ready=1 -> outputs 1..8 on consecutive cycles; in_ready stays 1 throughout.
3. Stall/skid: send {620,240,100} then {380,170,450} with out_ready=0 -> in_ready=0 after the second acceptance; out_data held at {620,240,100}. Raise out_ready -> outputs {620,240,100} then {380,170,450}, in order.
4. Flush in FULL with simultaneous in_valid=1 -> next edge out_valid=0, out_ctrl=0, in_ready=1; the incoming entry never appears.
5. Asynchronous reset mid-stall: assert reset between edges while FULL -> out_valid=0, out_ctrl=0, in_ready=1 immediately, before the next edge.
6. PIPE_STAGE_STATS_EN, COUNT_W=4: hold out_valid=1 and out_ready=0 for 20 cycles -> stall_count=15 (saturated); flush leaves it at 15; reset clears it to 0.
